collision_scanner: RTL and testbench
====================================

# collision_scanner

Parametrised, frame-driven collision engine that tests the player rectangle against `NUM_OBJ` object rectangles, one object per clock, and reports hazard hits and collectible catches. It sits between the object generators and the game-state controller. It replaces per-object combinational comparators with a single time-shared comparator. It adds capabilities the single-object detector lacks:
- input snapshotting;
- overflow-safe arithmetic;
- sticky game-over;
- catch edge detection, so a held overlap scores once.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of object slots, range 1–16.
- `COORD_W`, 10: coordinate/size width.
- `PLAYER_WIDTH`, 30: player width in pixels.
- `PLAYER_Y`, 315: player bottom edge (y grows downward).
- `CNT_W`, 8: catch counter width.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: scan request pulse, normally the frame tick.
- `clear_game_over` in 1: clears the sticky `game_over` flag.
- `player_x` in `COORD_W`: player left edge.
- `player_height` in `COORD_W`: player height above `PLAYER_Y`.
- `obj_x`, `obj_y`, `obj_w`, `obj_h` in `NUM_OBJ*COORD_W` each: flattened object geometry; slot i occupies bits [i*COORD_W +: COORD_W].
- `obj_active` in `NUM_OBJ`: slot i is valid.
- `obj_kind` in `NUM_OBJ`: 0 = hazard, 1 = collectible.
- `busy` out 1: a scan is in progress.
- `done` out 1: one-cycle pulse when the scan completes.
- `hit_vec` out `NUM_OBJ`: overlap result per slot from the last completed scan.
- `catch_vec` out `NUM_OBJ`: collectibles newly caught in the last scan; valid while `done` is high, 0 otherwise.
- `game_over` out 1: sticky hazard-hit flag.
- `catch_count` out `CNT_W`: saturating total of catches.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN when `start`=1.
  - On that edge, snapshot all inputs into registers.
  - Compute the player top edge: `PLAYER_Y - player_height`, clamped to 0 when `player_height > PLAYER_Y`.
  - Set index `idx` = 0.
- SCAN: each cycle, evaluate slot `idx` against the snapshot.
  - `pend[idx]` = `obj_active[idx]` AND overlap.
  - Increment `idx`. Leave SCAN after slot `NUM_OBJ-1`.
- DONE (one cycle):
  - `done`=1.
  - `hit_vec` ← `pend`.
  - `catch_vec` = `pend` & `obj_kind` & ~`prev_hit`, where `prev_hit` is the `hit_vec` of the previous scan.
  - `catch_count` += popcount(`catch_vec`), saturating at all-ones.
  - `game_over` is set if any `pend` bit has kind 0.
  - Return to IDLE.
- Overlap test uses strict inequalities, so touching edges do not overlap:
  - `px < ox+ow`
  - `px+PLAYER_WIDTH > ox`
  - `ptop < oy+oh`
  - `PLAYER_Y > oy`
- All sums are computed at `COORD_W+1` bits; there is no wrap-around.
- `start` while `busy`=1 is ignored; no queueing.
- `clear_game_over` and a new hazard hit in the same cycle: set wins.
- Inactive slots never hit, regardless of geometry.
- A collectible that stays overlapped across consecutive scans is caught only once. It can be caught again after one scan with no overlap.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hit_vec`=0, `catch_vec`=0, `prev_hit`=0, `game_over`=0, `catch_count`=0.
- `start` sampled high at edge t:
  - `busy`=1 from t+1 through t+NUM_OBJ+1 inclusive.
  - `done`=1 in cycle t+NUM_OBJ+1.
  - `hit_vec`, `catch_vec`, `game_over` and `catch_count` update at that same edge.
- Latency is NUM_OBJ+1 cycles. Earliest accepted restart is the cycle after `done`.
- Inputs are ignored after the snapshot; changes mid-scan do not affect the result.
- `reset` mid-scan: abort at the next edge and load all reset values; no `done` is produced.

## Structure
- Package `collision_pkg`:
  - `KIND_HAZARD`=0, `KIND_COLLECT`=1.
  - FSM state encoding.
  - Overlap helper function with width-extended arithmetic.
- Sub-module `rect_overlap`: combinational, parametrised by `COORD_W`, one instance time-shared across slots.
- Saturating popcount/adder inline.

## Test plan
- `NUM_OBJ`=4, player_x=100, player_height=30; slot 2 hazard at (110,300,20,20), active; `start` → `done` at cycle 5, `hit_vec`=4'b0100, `game_over`=1, `catch_count`=0.
- Slot 1 collectible at (90,290,20,20), overlap held for 3 scans → `catch_vec`=4'b0010 on the first scan only, `catch_count`=1. Move away 1 scan, then return → `catch_count`=2.
- Edge-touch: obstacle x=130 with player_x=100 → no hit. Object x=1020, w=20 with player_x=1000 → hit, no wrap. player_height=400 → top clamped to 0.
- Modify `obj_x` and pulse `start` mid-scan → result reflects the snapshot, second `start` ignored, exactly one `done`.
- `reset` at the 2nd SCAN cycle → all outputs 0, no `done`. `clear_game_over` coincident with a hazard `done` → `game_over` stays 1.
- `catch_count` preset near 8'hFF, 2 simultaneous catches → 8'hFF. Inactive overlapping slot → `hit_vec` bit 0.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared definitions for the collision scanner: object kinds, scan FSM
// states and the rectangle overlap test used by the time-shared comparator.
package collision_pkg;

  localparam logic KIND_HAZARD  = 1'b0;
  localparam logic KIND_COLLECT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Strict-inequality overlap of the player box against one object box.
  // Inputs arrive zero-extended to 32 bits and every sum is formed one bit
  // wider, so an object hanging past the right/bottom border never wraps.
  function automatic logic rect_overlap_test(
    input logic [31:0] px,
    input logic [31:0] pw,
    input logic [31:0] ptop,
    input logic [31:0] pbot,
    input logic [31:0] ox,
    input logic [31:0] oy,
    input logic [31:0] ow,
    input logic [31:0] oh
  );
    logic [32:0] obj_right;
    logic [32:0] obj_bottom;
    logic [32:0] player_right;
    obj_right    = {1'b0, ox} + {1'b0, ow};
    obj_bottom   = {1'b0, oy} + {1'b0, oh};
    player_right = {1'b0, px} + {1'b0, pw};
    return ({1'b0, px} < obj_right) &&
           (player_right > {1'b0, ox}) &&
           ({1'b0, ptop} < obj_bottom) &&
           (pbot > oy);
  endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Bus between the game logic and the collision scanner: scan request,
// per-frame player/object geometry, and the scan results.
interface collision_scanner_if #(
  parameter int NUM_OBJ = 4,
  parameter int COORD_W = 10,
  parameter int CNT_W   = 8
);

  logic                       start;
  logic                       clear_game_over;
  logic [COORD_W-1:0]         player_x;
  logic [COORD_W-1:0]         player_height;
  logic [NUM_OBJ*COORD_W-1:0] obj_x;
  logic [NUM_OBJ*COORD_W-1:0] obj_y;
  logic [NUM_OBJ*COORD_W-1:0] obj_w;
  logic [NUM_OBJ*COORD_W-1:0] obj_h;
  logic [NUM_OBJ-1:0]         obj_active;
  logic [NUM_OBJ-1:0]         obj_kind;

  logic                       busy;
  logic                       done;
  logic [NUM_OBJ-1:0]         hit_vec;
  logic [NUM_OBJ-1:0]         catch_vec;
  logic                       game_over;
  logic [CNT_W-1:0]           catch_count;

  // Game-state side: issues scans and supplies geometry.
  modport master (
    output start, clear_game_over, player_x, player_height,
    output obj_x, obj_y, obj_w, obj_h, obj_active, obj_kind,
    input  busy, done, hit_vec, catch_vec, game_over, catch_count
  );

  // Scanner side.
  modport slave (
    input  start, clear_game_over, player_x, player_height,
    input  obj_x, obj_y, obj_w, obj_h, obj_active, obj_kind,
    output busy, done, hit_vec, catch_vec, game_over, catch_count
  );

endinterface

// File: rtl/rect_overlap.sv
// Combinational player-versus-object overlap comparator. A single instance
// is shared by all object slots, one slot per clock.
module rect_overlap
  import collision_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int PLAYER_WIDTH = 30,
  parameter int PLAYER_Y     = 315
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] ptop,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic [COORD_W-1:0] ow,
  input  logic [COORD_W-1:0] oh,
  output logic               hit
);

  // Evaluate the strict overlap test with widened arithmetic.
  always_comb begin
    hit = rect_overlap_test(32'(px), 32'(PLAYER_WIDTH), 32'(ptop), 32'(PLAYER_Y),
                            32'(ox), 32'(oy), 32'(ow), 32'(oh));
  end

endmodule

// File: rtl/collision_scanner.sv
// Frame-driven collision engine: snapshots the player and all object slots
// on start, walks the slots one per clock through a shared comparator, then
// publishes hits, newly caught collectibles, the sticky game-over flag and
// a saturating catch total.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = 10,
  parameter int PLAYER_WIDTH = 30,
  parameter int PLAYER_Y     = 315,
  parameter int CNT_W        = 8
) (
  input logic          clk,
  input logic          reset,
  collision_scanner_if.slave bus
);

  localparam int                 IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [COORD_W-1:0] PY       = COORD_W'(PLAYER_Y);
  localparam int                 CNT_MAX  = (1 << CNT_W) - 1;

  scan_state_t                state;
  scan_state_t                next_state;
  logic [IDX_W-1:0]           idx;

  logic [COORD_W-1:0]         player_top;
  logic [COORD_W-1:0]         snap_px;
  logic [COORD_W-1:0]         snap_ptop;
  logic [NUM_OBJ*COORD_W-1:0] snap_x;
  logic [NUM_OBJ*COORD_W-1:0] snap_y;
  logic [NUM_OBJ*COORD_W-1:0] snap_w;
  logic [NUM_OBJ*COORD_W-1:0] snap_h;
  logic [NUM_OBJ-1:0]         snap_active;
  logic [NUM_OBJ-1:0]         snap_kind;
  logic [NUM_OBJ-1:0]         pend;

  logic [COORD_W-1:0]         slot_x;
  logic [COORD_W-1:0]         slot_y;
  logic [COORD_W-1:0]         slot_w;
  logic [COORD_W-1:0]         slot_h;
  logic                       slot_overlap;
  logic                       slot_hit;
  logic                       scan_last;

  logic [NUM_OBJ-1:0]         prev_hit;
  logic [NUM_OBJ-1:0]         pend_final;
  logic [NUM_OBJ-1:0]         new_catch;
  logic                       hazard_any;
  logic                       done_hazard;
  int                         catch_pop;
  int                         count_sum;
  logic [CNT_W-1:0]           count_next;

  // Player top edge, clamped at the screen top when the player is taller
  // than its baseline height.
  always_comb begin
    player_top = (bus.player_height > PY) ? '0 : PY - bus.player_height;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: start is only honoured from IDLE, so requests while
  // busy are dropped rather than queued.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.start) next_state = ST_SCAN;
      ST_SCAN: if (idx == LAST_IDX) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);

  // Snapshot inputs on an accepted start, then record one slot result per
  // scan cycle; inputs are not looked at again until the next scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      snap_px     <= '0;
      snap_ptop   <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_w      <= '0;
      snap_h      <= '0;
      snap_active <= '0;
      snap_kind   <= '0;
      pend        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            idx         <= '0;
            snap_px     <= bus.player_x;
            snap_ptop   <= player_top;
            snap_x      <= bus.obj_x;
            snap_y      <= bus.obj_y;
            snap_w      <= bus.obj_w;
            snap_h      <= bus.obj_h;
            snap_active <= bus.obj_active;
            snap_kind   <= bus.obj_kind;
            pend        <= '0;
          end
        end
        ST_SCAN: begin
          pend[idx] <= slot_hit;
          idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Select the geometry of the slot currently under test.
  always_comb begin
    slot_x = snap_x[int'(idx)*COORD_W +: COORD_W];
    slot_y = snap_y[int'(idx)*COORD_W +: COORD_W];
    slot_w = snap_w[int'(idx)*COORD_W +: COORD_W];
    slot_h = snap_h[int'(idx)*COORD_W +: COORD_W];
  end

  rect_overlap #(
    .COORD_W      (COORD_W),
    .PLAYER_WIDTH (PLAYER_WIDTH),
    .PLAYER_Y     (PLAYER_Y)
  ) u_overlap (
    .px   (snap_px),
    .ptop (snap_ptop),
    .ox   (slot_x),
    .oy   (slot_y),
    .ow   (slot_w),
    .oh   (slot_h),
    .hit  (slot_overlap)
  );

  assign slot_hit  = slot_overlap & snap_active[idx];
  assign scan_last = (state == ST_SCAN) && (idx == LAST_IDX);
  // The published hit vector doubles as the previous scan's result.
  assign prev_hit  = bus.hit_vec;

  // Final scan result including the slot being evaluated on the last scan
  // cycle, plus catch edge detection and the saturating counter update.
  always_comb begin
    pend_final      = pend;
    pend_final[idx] = slot_hit;
    new_catch       = '0;
    hazard_any      = 1'b0;
    catch_pop       = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (pend_final[i] && (snap_kind[i] == KIND_COLLECT) && !prev_hit[i]) begin
        new_catch[i] = 1'b1;
        catch_pop    = catch_pop + 1;
      end
      if (pend_final[i] && (snap_kind[i] == KIND_HAZARD)) begin
        hazard_any = 1'b1;
      end
    end
    count_sum  = int'(bus.catch_count) + catch_pop;
    count_next = (count_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(count_sum);
  end

  // Publish results on the edge that enters DONE. catch_vec is shown only
  // for the DONE cycle. A hazard from this scan overrides clear_game_over
  // both on that edge and for the whole DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.hit_vec     <= '0;
      bus.catch_vec   <= '0;
      bus.catch_count <= '0;
      bus.game_over   <= 1'b0;
      done_hazard     <= 1'b0;
    end else begin
      if (scan_last) begin
        bus.hit_vec     <= pend_final;
        bus.catch_vec   <= new_catch;
        bus.catch_count <= count_next;
        done_hazard     <= hazard_any;
      end else begin
        bus.catch_vec   <= '0;
        done_hazard     <= 1'b0;
      end
      if ((scan_last && hazard_any) || ((state == ST_DONE) && done_hazard)) begin
        bus.game_over <= 1'b1;
      end else if (bus.clear_game_over) begin
        bus.game_over <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: each accepted scan pushes the
// expected result computed from a geometric reference model; a negedge
// monitor compares whenever done is presented.
module tb_collision_scanner;

  localparam int NUM_OBJ = 4;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 8;
  localparam int PW      = 30;
  localparam int PY      = 315;
  localparam int CMAX    = 255;

  typedef struct {
    int hit;
    int catchv;
    int go;
    int cnt;
    int start_cyc;
    int done_at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int   m_prev;
  int   m_count;
  int   m_go;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  collision_scanner_if #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .CNT_W(CNT_W)) bus();

  collision_scanner #(
    .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .PLAYER_WIDTH(PW),
    .PLAYER_Y(PY), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit model_hit(int px, int ph, int ox, int oy, int ow, int oh);
    int ptop;
    ptop = (ph > PY) ? 0 : PY - ph;
    return (px < ox + ow) && (px + PW > ox) && (ptop < oy + oh) && (PY > oy);
  endfunction

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                         input bit act, input bit kind);
    bus.obj_x[i*COORD_W +: COORD_W] = 10'(x);
    bus.obj_y[i*COORD_W +: COORD_W] = 10'(y);
    bus.obj_w[i*COORD_W +: COORD_W] = 10'(w);
    bus.obj_h[i*COORD_W +: COORD_W] = 10'(h);
    bus.obj_active[i] = act;
    bus.obj_kind[i]   = kind;
  endtask

  task automatic all_inactive();
    for (int i = 0; i < NUM_OBJ; i++) set_obj(i, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // Wait for idle, compute the expected result, then pulse start.
  task automatic applyStimulus();
    int g;
    exp_t e;
    int hit, pop;
    g = 0;
    while (bus.busy && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) checkOutput("idle_timeout", 1, 0);
    hit = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (bus.obj_active[i] &&
          model_hit(int'(bus.player_x), int'(bus.player_height),
                    int'(bus.obj_x[i*COORD_W +: COORD_W]), int'(bus.obj_y[i*COORD_W +: COORD_W]),
                    int'(bus.obj_w[i*COORD_W +: COORD_W]), int'(bus.obj_h[i*COORD_W +: COORD_W])))
        hit |= (1 << i);
    end
    e.hit    = hit;
    e.catchv = hit & int'(bus.obj_kind) & ~m_prev & 'hF;
    pop = 0;
    for (int i = 0; i < NUM_OBJ; i++) if (e.catchv[i]) pop++;
    m_count = (m_count + pop > CMAX) ? CMAX : m_count + pop;
    if ((hit & ~int'(bus.obj_kind) & 'hF) != 0) m_go = 1;
    m_prev      = hit;
    e.go        = m_go;
    e.cnt       = m_count;
    e.start_cyc = cyc;
    e.done_at   = cyc + NUM_OBJ + 1;
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 30) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 30) begin
      checkOutput("done_timeout", 1, 0);
      exp_q.delete();
    end
  endtask

  task automatic clear_go();
    bus.clear_game_over = 1'b1;
    @(posedge clk); #1;
    bus.clear_game_over = 1'b0;
    m_go = 0;
    checkOutput("go_cleared", int'(bus.game_over), 0);
  endtask

  task automatic scan();
    applyStimulus();
    wait_done();
  endtask

  // Monitor: busy window, done timing and result fields against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int exp_busy;
    if (!reset) begin
      exp_busy = (exp_q.size() > 0 && cyc > exp_q[0].start_cyc && cyc <= exp_q[0].done_at) ? 1 : 0;
      checkOutput("busy", int'(bus.busy), exp_busy);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_cycle", cyc, e.done_at);
          checkOutput("hit_vec", int'(bus.hit_vec), e.hit);
          checkOutput("catch_vec", int'(bus.catch_vec), e.catchv);
          checkOutput("game_over", int'(bus.game_over), e.go);
          checkOutput("catch_count", int'(bus.catch_count), e.cnt);
        end
      end else begin
        checkOutput("catch_vec_idle", int'(bus.catch_vec), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.clear_game_over = 1'b0;
    bus.player_x = '0;
    bus.player_height = '0;
    all_inactive();
    m_prev = 0; m_count = 0; m_go = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_hit", int'(bus.hit_vec), 0);
    checkOutput("rst_catch", int'(bus.catch_vec), 0);
    checkOutput("rst_go", int'(bus.game_over), 0);
    checkOutput("rst_cnt", int'(bus.catch_count), 0);

    // Hazard in slot 2.
    bus.player_x = 10'd100; bus.player_height = 10'd30;
    set_obj(2, 110, 300, 20, 20, 1'b1, 1'b0);
    scan();
    checkOutput("t1_hit", int'(bus.hit_vec), 4'b0100);
    checkOutput("t1_go", int'(bus.game_over), 1);
    checkOutput("t1_cnt", int'(bus.catch_count), 0);
    clear_go();

    // Held collectible scores once, again after a gap.
    all_inactive();
    set_obj(1, 90, 290, 20, 20, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      scan();
      checkOutput("hold_cnt", int'(bus.catch_count), 1);
    end
    set_obj(1, 500, 290, 20, 20, 1'b1, 1'b1);
    scan();
    checkOutput("away_hit", int'(bus.hit_vec), 0);
    set_obj(1, 90, 290, 20, 20, 1'b1, 1'b1);
    scan();
    checkOutput("return_cnt", int'(bus.catch_count), 2);

    // Boundaries: touching edge, right-border object, clamped top.
    all_inactive();
    set_obj(0, 130, 300, 20, 20, 1'b1, 1'b0);
    scan();
    checkOutput("touch_hit", int'(bus.hit_vec), 0);
    bus.player_x = 10'd1000;
    set_obj(0, 1020, 300, 20, 20, 1'b1, 1'b0);
    scan();
    checkOutput("nowrap_hit", int'(bus.hit_vec), 4'b0001);
    clear_go();
    all_inactive();
    bus.player_x = 10'd100; bus.player_height = 10'd400;
    set_obj(3, 100, 0, 20, 10, 1'b1, 1'b0);
    scan();
    checkOutput("clamp_hit", int'(bus.hit_vec), 4'b1000);
    clear_go();

    // Inactive overlapping slot never hits.
    all_inactive();
    bus.player_height = 10'd30;
    set_obj(0, 110, 300, 20, 20, 1'b0, 1'b0);
    scan();
    checkOutput("inactive_hit", int'(bus.hit_vec), 0);

    // Mid-scan input change and ignored restart.
    set_obj(2, 110, 300, 20, 20, 1'b1, 1'b0);
    applyStimulus();
    @(posedge clk); #1;
    set_obj(2, 600, 300, 20, 20, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
    checkOutput("snap_hit", int'(bus.hit_vec), 4'b0100);
    repeat (8) @(posedge clk);
    #1 clear_go();

    // Reset on the second scan cycle aborts without done.
    set_obj(2, 110, 300, 20, 20, 1'b1, 1'b0);
    applyStimulus();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    m_prev = 0; m_count = 0; m_go = 0;
    reset = 1'b0;
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_hit", int'(bus.hit_vec), 0);
    checkOutput("abort_go", int'(bus.game_over), 0);
    checkOutput("abort_cnt", int'(bus.catch_count), 0);
    repeat (8) @(posedge clk);
    #1;

    // clear_game_over held across a hazard scan's completion: set wins.
    applyStimulus();
    bus.clear_game_over = 1'b1;
    wait_done();
    bus.clear_game_over = 1'b0;
    checkOutput("set_wins_go", int'(bus.game_over), 1);
    clear_go();

    // Saturation with two catches per scan.
    all_inactive();
    for (int k = 0; k < 130; k++) begin
      set_obj(0, 95, 300, 20, 20, 1'b1, 1'b1);
      set_obj(1, 110, 290, 20, 20, 1'b1, 1'b1);
      scan();
      set_obj(0, 600, 300, 20, 20, 1'b1, 1'b1);
      set_obj(1, 700, 290, 20, 20, 1'b1, 1'b1);
      scan();
    end
    checkOutput("sat_cnt", int'(bus.catch_count), 8'hFF);

    // Randomized scans against the reference model.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_prev = 0; m_count = 0; m_go = 0;
    for (int k = 0; k < 200; k++) begin
      bus.player_x = 10'($urandom_range(60, 140));
      bus.player_height = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(300, 500))
                                                      : 10'($urandom_range(0, 80));
      for (int i = 0; i < NUM_OBJ; i++)
        set_obj(i, $urandom_range(40, 200), $urandom_range(230, 340), $urandom_range(1, 40),
                $urandom_range(1, 40), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) clear_go();
      scan();
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
